// File: rtl/shift_arb_ctrl.sv
// Purpose: two-requester round-robin arbiter that time-shares one combinational shifter.
// Latency: response valid 2 cycles after the accept cycle (3 for a two-pass rotate).
// Backpressure: req ready only in IDLE for the granted requester; RESP holds until rsp_ready.
//
// Ports:
//   clk, reset                     single clock, asynchronous active-high reset
//   reqN_valid/reqN_ready          request handshake, N = 0/1
//   reqN_a, reqN_b, reqN_sfn       operand, shift amount, op (00 LSL, 01 LSR, 11 ASR, 10 ROL)
//   sh_a, sh_b, sh_sfn, sh_y       operands to / same-cycle result from the shared shifter
//   rsp_valid/rsp_ready            response handshake; rsp_id = served requester, rsp_y = result
// Build option: define SHIFT_ARB_ROTATE_EN to execute op 10 as a two-pass rotate-left;
//   otherwise op 10 returns zero.
module shift_arb_ctrl #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [4:0]  req0_b,
    input  logic [1:0]  req0_sfn,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [4:0]  req1_b,
    input  logic [1:0]  req1_sfn,
    output logic [31:0] sh_a,
    output logic [4:0]  sh_b,
    output logic [1:0]  sh_sfn,
    input  logic [31:0] sh_y,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_y,
    input  logic        rsp_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ROT2 = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        pri;
    logic        gnt_id;
    logic [31:0] op_a;
    logic [4:0]  op_b;
    logic [1:0]  op_sfn;
    logic        op_id;
    logic [31:0] rsp_y_q;
    logic [31:0] rsp_y_nxt;
    logic        load_op;
    logic        load_rsp;
`ifdef SHIFT_ARB_ROTATE_EN
    logic [31:0] part;
    logic        load_part;
`endif

    // A lone requester wins outright; on contention the priority pointer decides.
    assign gnt_id = (req0_valid && req1_valid) ? pri : req1_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        sh_a       = '0;
        sh_b       = '0;
        sh_sfn     = '0;
        rsp_valid  = 1'b0;
        load_op    = 1'b0;
        load_rsp   = 1'b0;
        rsp_y_nxt  = '0;
`ifdef SHIFT_ARB_ROTATE_EN
        load_part  = 1'b0;
`endif
        case (state)
            IDLE: begin
                req0_ready = req0_valid && !gnt_id;
                req1_ready = req1_valid && gnt_id;
                if (req0_valid || req1_valid) begin
                    load_op   = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                sh_a = op_a;
                sh_b = op_b;
`ifdef SHIFT_ARB_ROTATE_EN
                if (op_sfn == 2'b10) begin
                    // First rotate pass is a plain left shift; a zero amount needs no second pass.
                    sh_sfn = 2'b00;
                    if (op_b != 5'd0) begin
                        load_part = 1'b1;
                        state_nxt = ROT2;
                    end else begin
                        load_rsp  = 1'b1;
                        rsp_y_nxt = sh_y;
                        state_nxt = RESP;
                    end
                end else begin
                    sh_sfn    = op_sfn;
                    load_rsp  = 1'b1;
                    rsp_y_nxt = sh_y;
                    state_nxt = RESP;
                end
`else
                sh_sfn    = op_sfn;
                load_rsp  = 1'b1;
                // Op 10 is not supported in this build and always returns zero.
                rsp_y_nxt = (op_sfn == 2'b10) ? 32'd0 : sh_y;
                state_nxt = RESP;
`endif
            end
            ROT2: begin
`ifdef SHIFT_ARB_ROTATE_EN
                // Second pass brings the wrapped-out high bits back in at the bottom.
                sh_a      = op_a;
                sh_b      = 5'd0 - op_b;
                sh_sfn    = 2'b01;
                load_rsp  = 1'b1;
                rsp_y_nxt = part | sh_y;
                state_nxt = RESP;
`else
                state_nxt = IDLE;
`endif
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pri     <= RR_INIT;
            op_a    <= '0;
            op_b    <= '0;
            op_sfn  <= '0;
            op_id   <= 1'b0;
            rsp_y_q <= '0;
`ifdef SHIFT_ARB_ROTATE_EN
            part    <= '0;
`endif
        end else begin
            if (load_op) begin
                op_a   <= gnt_id ? req1_a   : req0_a;
                op_b   <= gnt_id ? req1_b   : req0_b;
                op_sfn <= gnt_id ? req1_sfn : req0_sfn;
                op_id  <= gnt_id;
            end
`ifdef SHIFT_ARB_ROTATE_EN
            if (load_part) begin
                part <= sh_y;
            end
`endif
            if (load_rsp) begin
                rsp_y_q <= rsp_y_nxt;
            end
            // Priority only moves when a response is actually delivered.
            if (state == RESP && rsp_ready) begin
                pri <= ~op_id;
            end
        end
    end

    assign rsp_id = op_id;
    assign rsp_y  = rsp_y_q;

endmodule

// File: tb/tb_shift_arb_ctrl.sv
// Purpose: directed self-checking bench for shift_arb_ctrl with a behavioural shared shifter.
// Latency: checks response timing relative to the accept cycle.
// Backpressure: exercises rsp_ready stalls and contention between both requesters.
module tb_shift_arb_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req1_a;
    logic [4:0]  req0_b, req1_b;
    logic [1:0]  req0_sfn, req1_sfn;
    logic [31:0] sh_a;
    logic [4:0]  sh_b;
    logic [1:0]  sh_sfn;
    logic [31:0] sh_y;
    logic        rsp_valid, rsp_id, rsp_ready;
    logic [31:0] rsp_y;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_arb_ctrl #(.RR_INIT(1'b0)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sfn   (req0_sfn),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sfn   (req1_sfn),
        .sh_a       (sh_a),
        .sh_b       (sh_b),
        .sh_sfn     (sh_sfn),
        .sh_y       (sh_y),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_y      (rsp_y),
        .rsp_ready  (rsp_ready)
    );

    // Shared shifter: op 10 yields zero.
    always_comb begin
        case (sh_sfn)
            2'b00:   sh_y = sh_a << sh_b;
            2'b01:   sh_y = sh_a >> sh_b;
            2'b11:   sh_y = $unsigned($signed(sh_a) >>> sh_b);
            default: sh_y = 32'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge with the block in IDLE; rsp_ready must be 1.
    task automatic run_req(input string tag, input logic id, input logic [31:0] a,
                           input logic [4:0] b, input logic [1:0] sfn,
                           input logic [31:0] exp_y, input int exp_lat);
        int n;
        if (id) begin
            req1_a = a; req1_b = b; req1_sfn = sfn; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_sfn = sfn; req0_valid = 1'b1;
        end
        @(negedge clk);
        chk({tag, "_rdy"}, id ? req1_ready : req0_ready, 1);
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 8);
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_y"}, rsp_y, exp_y);
        chk({tag, "_id"}, rsp_id, id);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, acc1, nacc;
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_sfn = 0;
        req1_a = 0; req1_b = 0; req1_sfn = 0;
        rsp_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_y", rsp_y, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_sh_a", sh_a, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Ready from the first cycle out of reset; basic LSL
        run_req("lsl", 0, 32'h0000_00F0, 5'd4, 2'b00, 32'h0000_0F00, 2);

        // Contention straight after reset: req0 first, then req1
        reset = 1'b1; #1; reset = 1'b0;
        req0_a = 32'h8000_0000; req0_b = 5'd31; req0_sfn = 2'b11; req0_valid = 1;
        req1_a = 32'h8000_0000; req1_b = 5'd31; req1_sfn = 2'b01; req1_valid = 1;
        @(negedge clk);
        chk("arb_r0", req0_ready, 1);
        chk("arb_r1", req1_ready, 0);
        @(posedge clk); #1; req0_valid = 0;
        @(negedge clk);
        chk("exec_sh_a", sh_a, 32'h8000_0000);
        chk("exec_sh_sfn", sh_sfn, 2'b11);
        chk("exec_r1_ign", req1_ready, 0);
        @(negedge clk);
        chk("asr_valid", rsp_valid, 1);
        chk("asr_y", rsp_y, 32'hFFFF_FFFF);
        chk("asr_id", rsp_id, 0);
        chk("resp_sh_b", sh_b, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("arb2_r1", req1_ready, 1);
        @(posedge clk); #1; req1_valid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("lsr_y", rsp_y, 32'h0000_0001);
        chk("lsr_id", rsp_id, 1);
        @(posedge clk); #1;
        // Priority back to req0 after serving req1
        req1_valid = 1;
        run_req("pri0", 0, 32'h0000_0001, 5'd0, 2'b01, 32'h0000_0001, 2);
        req1_valid = 0;

        // Response stall with rsp_ready low for 5 cycles
        rsp_ready = 0;
        req1_a = 32'hFFFF_0000; req1_b = 5'd8; req1_sfn = 2'b01; req1_valid = 1;
        @(negedge clk);
        chk("stall_r1", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 0;
        req0_a = 32'h0000_0001; req0_b = 5'd31; req0_sfn = 2'b00; req0_valid = 1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_valid", rsp_valid, 1);
            chk("stall_y", rsp_y, 32'h00FF_FF00);
            chk("stall_id", rsp_id, 1);
            chk("stall_r0", req0_ready, 0);
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        run_req("after_stall", 0, 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 2);

        // Single requester held valid: back-to-back every 3 cycles
        req0_a = 32'h1234_5678; req0_b = 5'd4; req0_sfn = 2'b00; req0_valid = 1;
        acc0 = -1; acc1 = -1; nacc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (req0_ready) begin
                if (nacc == 0) acc0 = i; else if (nacc == 1) acc1 = i;
                nacc++;
            end
            if (rsp_valid) chk("b2b_y", rsp_y, 32'h2345_6780);
        end
        req0_valid = 0;
        @(posedge clk); #1;
        chk("b2b_gap", acc1 - acc0, 3);
        chk("b2b_count", nacc, 4);

        // Op 10 (rotate-left or zero)
`ifdef SHIFT_ARB_ROTATE_EN
        run_req("rol1", 0, 32'h8000_0001, 5'd1, 2'b10, 32'h0000_0003, 3);
        run_req("rol4", 0, 32'hF000_000F, 5'd4, 2'b10, 32'h0000_00FF, 3);
        run_req("rol0", 0, 32'h8000_0001, 5'd0, 2'b10, 32'h8000_0001, 2);
`else
        run_req("rol1", 0, 32'h8000_0001, 5'd1, 2'b10, 32'h0000_0000, 2);
        run_req("rol4", 0, 32'hF000_000F, 5'd4, 2'b10, 32'h0000_0000, 2);
        run_req("rol0", 0, 32'h8000_0001, 5'd0, 2'b10, 32'h0000_0000, 2);
`endif

        // Reset during EXEC discards the operation and restores priority
        req0_a = 32'h0000_FFFF; req0_b = 5'd8; req0_sfn = 2'b00; req0_valid = 1;
        @(negedge clk);
        @(posedge clk); #1;
        req0_valid = 0;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_y", rsp_y, 0);
        req1_a = 32'h0000_0010; req1_b = 5'd1; req1_sfn = 2'b00; req1_valid = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("in_rst_valid", rsp_valid, 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        run_req("post_rst", 0, 32'h7FFF_0000, 5'd16, 2'b11, 32'h0000_7FFF, 2);
        req1_valid = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
